// File: rtl/axi_write_req_gen.sv
// ============================================================================
// Module   : axi_write_req_gen
// Brief    : Single-outstanding AXI write burst generator (AW, W, B sequencing)
//            with a zero-latency data pass-through. Optional B-response
//            watchdog enabled by defining AXI_WR_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_write_req_gen #(
    parameter int AW             = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [7:0]    req_len,
    input  logic [2:0]    req_size,
    input  logic [1:0]    req_burst,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic [63:0]   din_data,
    input  logic [7:0]    din_strb,
    output logic [AW-1:0] awaddr_in,
    output logic [7:0]    awlen_in,
    output logic [2:0]    awsize_in,
    output logic [1:0]    awburst_in,
    output logic          awvalid_in,
    input  logic          axi_awready,
    output logic [63:0]   wdata_in,
    output logic [7:0]    wstrb_in,
    output logic          wlast,
    output logic          wvalid_in,
    input  logic          axi_wready,
    input  logic          axi_bvalid,
    input  logic [1:0]    axi_bresp,
    output logic          bready_in,
    output logic          done_valid,
    output logic [1:0]    done_resp
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADDR = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;
    localparam logic [1:0] c_RESP = 2'd3;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_req_ready;
    logic [AW-1:0] r_awaddr;
    logic [7:0]    r_awlen;
    logic [2:0]    r_awsize;
    logic [1:0]    r_awburst;
    logic [7:0]    r_beat_cnt;
    logic          r_done_valid;
    logic [1:0]    r_done_resp;

    logic w_in_data;
    logic w_req_hs;
    logic w_w_hs;
    logic w_last_beat;
    logic w_timeout;
    logic w_finish;

    assign w_in_data   = (r_state == c_DATA);
    assign w_req_hs    = req_valid && r_req_ready;
    assign w_w_hs      = w_in_data && din_valid && axi_wready;
    assign w_last_beat = (r_beat_cnt == r_awlen);
    assign w_finish    = (r_state == c_RESP) && (axi_bvalid || w_timeout);

`ifdef AXI_WR_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT_CYCLES - 1);

    logic [c_TW-1:0] r_to_cnt;

    // Counts silent RESP cycles; held at zero everywhere else so each RESP entry starts fresh.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_to_cnt <= '0;
        end else if (r_state != c_RESP) begin
            r_to_cnt <= '0;
        end else if (!axi_bvalid) begin
            r_to_cnt <= r_to_cnt + c_TW'(1);
        end
    end

    assign w_timeout = (r_state == c_RESP) && !axi_bvalid && (r_to_cnt == c_TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_req_hs)                 w_state_nxt = c_ADDR;
            c_ADDR:  if (axi_awready)              w_state_nxt = c_DATA;
            c_DATA:  if (w_w_hs && w_last_beat)    w_state_nxt = c_RESP;
            c_RESP:  if (axi_bvalid || w_timeout)  w_state_nxt = c_IDLE;
            default:                               w_state_nxt = c_IDLE;
        endcase
    end

    // req_ready is registered so it stays low for the first cycle out of reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= c_IDLE;
            r_req_ready  <= 1'b0;
            r_awaddr     <= '0;
            r_awlen      <= '0;
            r_awsize     <= '0;
            r_awburst    <= '0;
            r_beat_cnt   <= '0;
            r_done_valid <= 1'b0;
            r_done_resp  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_req_ready  <= (w_state_nxt == c_IDLE);
            r_done_valid <= w_finish;
            if (w_req_hs) begin
                r_awaddr   <= req_addr;
                r_awlen    <= req_len;
                r_awsize   <= req_size;
                r_awburst  <= req_burst;
                r_beat_cnt <= '0;
            end else if (w_w_hs && !w_last_beat) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
            if (w_finish) begin
                r_done_resp <= axi_bvalid ? axi_bresp : c_RESP_SLVERR;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign awaddr_in  = r_awaddr;
    assign awlen_in   = r_awlen;
    assign awsize_in  = r_awsize;
    assign awburst_in = r_awburst;
    assign awvalid_in = (r_state == c_ADDR);
    assign wvalid_in  = w_in_data && din_valid;
    assign din_ready  = w_in_data && axi_wready;
    assign wdata_in   = w_in_data ? din_data : 64'd0;
    assign wstrb_in   = w_in_data ? din_strb : 8'd0;
    assign wlast      = w_in_data && w_last_beat;
    assign bready_in  = (r_state == c_RESP);
    assign done_valid = r_done_valid;
    assign done_resp  = r_done_resp;

endmodule

`default_nettype wire

// File: tb/tb_axi_write_req_gen.sv
// Bench for axi_write_req_gen: vector table of bursts plus hand-written reset
// and watchdog sequences, with queue-based scoreboards for W beats and completions.
`timescale 1ns/1ps
`default_nettype none

module tb_axi_write_req_gen;

    localparam int AW = 32;
    localparam int TO = 16;
`ifdef AXI_WR_TIMEOUT_EN
    localparam bit TO_DONE = 1'b1;
`else
    localparam bit TO_DONE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [7:0]    req_len = '0;
    logic [2:0]    req_size = '0;
    logic [1:0]    req_burst = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic [63:0]   din_data = '0;
    logic [7:0]    din_strb = '0;
    logic [AW-1:0] awaddr_in;
    logic [7:0]    awlen_in;
    logic [2:0]    awsize_in;
    logic [1:0]    awburst_in;
    logic          awvalid_in;
    logic          axi_awready = 1'b0;
    logic [63:0]   wdata_in;
    logic [7:0]    wstrb_in;
    logic          wlast;
    logic          wvalid_in;
    logic          axi_wready = 1'b0;
    logic          axi_bvalid = 1'b0;
    logic [1:0]    axi_bresp = '0;
    logic          bready_in;
    logic          done_valid;
    logic [1:0]    done_resp;

    always #5 clk = ~clk;

    axi_write_req_gen #(.AW(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .req_size(req_size), .req_burst(req_burst),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_strb(din_strb),
        .awaddr_in(awaddr_in), .awlen_in(awlen_in), .awsize_in(awsize_in), .awburst_in(awburst_in),
        .awvalid_in(awvalid_in), .axi_awready(axi_awready),
        .wdata_in(wdata_in), .wstrb_in(wstrb_in), .wlast(wlast), .wvalid_in(wvalid_in),
        .axi_wready(axi_wready),
        .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp), .bready_in(bready_in),
        .done_valid(done_valid), .done_resp(done_resp)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } beat_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        int            aw_wait;
        int            b_delay;
        logic [1:0]    bresp;
        bit            rnd;
        int            exp_beats;
        int            exp_aw;
        logic [1:0]    exp_resp;
        bit            exp_done;
    } vec_t;

    beat_t      wq[$];
    logic [1:0] dq[$];
    vec_t       vecs[7];
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_awvalid"}, awvalid_in, 0);
        chk({tag, "_wvalid"}, wvalid_in, 0);
        chk({tag, "_wlast"}, wlast, 0);
        chk({tag, "_bready"}, bready_in, 0);
        chk({tag, "_done_valid"}, done_valid, 0);
        chk({tag, "_din_ready"}, din_ready, 0);
        chk({tag, "_aw_fields"}, {awaddr_in, awlen_in, awsize_in, awburst_in}, 0);
        chk({tag, "_done_resp"}, done_resp, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        req_valid = 1'b0; din_valid = 1'b0; axi_wready = 1'b0;
        axi_awready = 1'b0; axi_bvalid = 1'b0;
        @(negedge clk);
        #1;
        chk_all_zero("reset");
        resetn = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_release_req_ready", req_ready, 1);
    endtask

    task automatic run_burst(input vec_t v);
        logic [63:0] src_d[$];
        logic [7:0]  src_s[$];
        int aw_seen = 0, hs = 0, src_idx = 0, resp_cyc = 0, cyc;
        bit aw_done = 0, last_done = 0, b_taken = 0, got_done = 0;
        bit in_addr, in_data, in_resp, in_done;
        beat_t b;
        logic [1:0] r;
        wq.delete();
        dq.delete();
        for (int i = 0; i < v.exp_beats; i++) begin
            b.data = {$urandom, $urandom};
            b.strb = 8'($urandom);
            b.last = (i == v.exp_beats - 1);
            src_d.push_back(b.data);
            src_s.push_back(b.strb);
            wq.push_back(b);
        end
        @(negedge clk);
        req_valid = 1'b1; req_addr = v.addr; req_len = v.len;
        req_size = v.size; req_burst = v.burst;
        axi_awready = 1'b0; din_valid = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0;
        #1;
        chk("req_ready_idle", req_ready, 1);
        for (cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_addr = $urandom; req_len = 8'($urandom);
            req_size = 3'($urandom); req_burst = 2'($urandom);
            in_addr = !aw_done;
            in_data = aw_done && !last_done;
            in_resp = last_done && !b_taken;
            in_done = b_taken;
            axi_awready = in_addr ? (aw_seen >= v.aw_wait) : 1'($urandom);
            din_valid  = (in_data && !v.rnd) ? 1'b1 : 1'($urandom);
            axi_wready = (in_data && !v.rnd) ? 1'b1 : 1'($urandom);
            din_data = (src_idx < src_d.size()) ? src_d[src_idx] : {$urandom, $urandom};
            din_strb = (src_idx < src_s.size()) ? src_s[src_idx] : 8'($urandom);
            axi_bvalid = in_resp ? (v.b_delay >= 0 && resp_cyc >= v.b_delay)
                                 : (in_done ? 1'b0 : 1'($urandom));
            axi_bresp = in_resp ? v.bresp : 2'($urandom);
            #1;
            chk("req_ready", req_ready, in_done);
            chk("awvalid", awvalid_in, in_addr);
            if (in_addr)
                chk("aw_fields", {awaddr_in, awlen_in, awsize_in, awburst_in},
                    {v.addr, v.len, v.size, v.burst});
            chk("wvalid", wvalid_in, in_data && din_valid);
            chk("din_ready", din_ready, in_data && axi_wready);
            chk("bready", bready_in, in_resp);
            chk("done_valid", done_valid, in_done);
            if (in_data && din_valid && axi_wready) begin
                if (wq.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    b = wq.pop_front();
                    chk("wdata", wdata_in, b.data);
                    chk("wstrb", wstrb_in, b.strb);
                    chk("wlast", wlast, b.last);
                    hs++;
                    src_idx++;
                    if (b.last) last_done = 1;
                end
            end else if (!in_data) begin
                chk("wlast_outside_data", wlast, 0);
            end
            if (in_addr) begin
                aw_seen++;
                if (axi_awready) aw_done = 1;
            end
            if (in_resp) begin
                if (axi_bvalid) begin
                    dq.push_back(v.bresp);
                    b_taken = 1;
                end
`ifdef AXI_WR_TIMEOUT_EN
                else if (resp_cyc + 1 == TO) begin
                    dq.push_back(2'b10);
                    b_taken = 1;
                end
`endif
                resp_cyc++;
                if (!b_taken && resp_cyc >= 1000) break;
            end
            if (in_done) begin
                got_done = 1;
                if (dq.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    r = dq.pop_front();
                    chk("done_resp", done_resp, r);
                end
                break;
            end
        end
        chk("burst_in_budget", cyc < 4000, 1);
        chk("beat_count", hs, v.exp_beats);
        chk("awvalid_cycles", aw_seen, v.exp_aw);
        chk("done_seen", got_done, v.exp_done);
        if (got_done) begin
            @(negedge clk);
            axi_bvalid = 1'b0; din_valid = 1'b0; axi_bresp = 2'($urandom);
            #1;
            chk("done_one_cycle", done_valid, 0);
            chk("done_resp_held", done_resp, v.exp_resp);
            chk("req_ready_after_done", req_ready, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    initial begin
        //        addr          len     size  burst  awW bD  bresp  rnd beats aw resp   done
        vecs[0] = '{32'h0000_1000, 8'd3,   3'd3, 2'b01, 0, 2, 2'b00, 0, 4,   1, 2'b00, 1};
        vecs[1] = '{32'h2000_0040, 8'd0,   3'd3, 2'b01, 4, 0, 2'b01, 0, 1,   5, 2'b01, 1};
        vecs[2] = '{32'h0000_3000, 8'd7,   3'd3, 2'b01, 0, 1, 2'b00, 1, 8,   1, 2'b00, 1};
        vecs[3] = '{32'hFFFF_FFF8, 8'd255, 3'd3, 2'b00, 1, 3, 2'b11, 1, 256, 2, 2'b11, 1};
        vecs[4] = '{32'h0000_0000, 8'd1,   3'd2, 2'b10, 2, 0, 2'b10, 1, 2,   3, 2'b10, 1};
        vecs[5] = '{32'h0000_5000, 8'd3,   3'd3, 2'b01, 0, 0, 2'b00, 0, 4,   1, 2'b00, 1};
        vecs[6] = '{32'h0000_6000, 8'd0,   3'd3, 2'b01, 0, -1, 2'b00, 0, 1,  1, 2'b10, TO_DONE};

        do_reset();
        for (int i = 0; i < 5; i++) run_burst(vecs[i]);

        // Reset in the middle of DATA after two of four beats
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_5000; req_len = 8'd3;
        req_size = 3'd3; req_burst = 2'b01;
        axi_awready = 1'b1; din_valid = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0;
        #1;
        chk("mid_req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("mid_awvalid", awvalid_in, 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            din_valid = 1'b1; axi_wready = 1'b1; din_data = 64'(k);
            #1;
            chk("mid_wvalid", wvalid_in, 1);
            chk("mid_wlast", wlast, 0);
        end
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1; din_valid = 1'b0; axi_wready = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk);
        #1;
        chk("mid_reset_req_ready", req_ready, 1);
        chk("mid_reset_no_done", done_valid, 0);
        run_burst(vecs[5]);

        // B response never arrives
        run_burst(vecs[6]);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_write_req_gen.md
AXI_WRITE_REQ_GEN -- requirements
Module: axi_write_req_gen

Interface
REQ-001 SHALL have parameter AW, default 32: address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256: B-response watchdog limit, used only with AXI_WR_TIMEOUT_EN.
REQ-003 SHALL have port clk  in  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  in  1: reset, synchronous and active-low.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1: burst request handshake.
REQ-006 SHALL have ports req_addr in AW, req_len in 8, req_size in 3, req_burst in 2: burst start address, beats-1, beat size, burst type.
REQ-007 SHALL have ports din_valid in 1, din_ready out 1, din_data in 64, din_strb in 8: write-data source stream.
REQ-008 SHALL have ports awaddr_in out AW, awlen_in out 8, awsize_in out 3, awburst_in out 2, awvalid_in out 1, axi_awready in 1: AW channel toward the write channel.
REQ-009 SHALL have ports wdata_in out 64, wstrb_in out 8, wlast out 1, wvalid_in out 1, axi_wready in 1: W channel toward the write channel.
REQ-010 SHALL have ports axi_bvalid in 1, axi_bresp in 2, bready_in out 1: B channel.
REQ-011 SHALL have ports done_valid out 1, done_resp out 2: one-cycle completion pulse and its response code.

Function
REQ-012 SHALL implement states IDLE, ADDR, DATA, RESP; only IDLE asserts req_ready.
REQ-013 SHALL, on req_valid&req_ready, register req_addr/len/size/burst onto awaddr_in/awlen_in/awsize_in/awburst_in, clear the beat counter, and enter ADDR; awvalid_in is high the next cycle.
REQ-014 SHALL hold awvalid_in high and AW fields stable in ADDR until axi_awready, then enter DATA with awvalid_in low the next cycle.
REQ-015 SHALL, in DATA only, drive wvalid_in=din_valid, din_ready=axi_wready, wdata_in=din_data, wstrb_in=din_strb combinationally (zero latency); outside DATA wvalid_in and din_ready are 0.
REQ-016 SHALL count W handshakes with an 8-bit beat counter and drive wlast=1 in DATA exactly when counter==awlen_in.
REQ-017 SHALL, on the handshake with wlast=1, enter RESP; req_len=0 yields a single-beat burst with wlast on the first beat; req_len=255 yields 256 beats with no counter wrap before wlast.
REQ-018 SHALL assert bready_in only in RESP; on axi_bvalid, pulse done_valid for one cycle with done_resp=axi_bresp and return to IDLE.
REQ-019 SHALL ignore axi_bvalid outside RESP and axi_awready outside ADDR.
REQ-020 SHALL not accept a new request until done_valid has been issued (one outstanding burst).
REQ-021 SHALL keep done_resp at its last value when done_valid is low.

Reset
REQ-022 SHALL, with resetn low at a clock edge, enter IDLE and drive awvalid_in, wvalid_in, wlast, bready_in, done_valid, din_ready, req_ready to 0 and AW fields, done_resp and beat counter to 0.
REQ-023 SHALL abandon any in-flight burst on reset mid-operation with no done_valid pulse; req_ready rises the first cycle after resetn returns high.

Configuration
REQ-024 SHALL, with AXI_WR_TIMEOUT_EN defined, count RESP cycles with axi_bvalid low; when count reaches TIMEOUT_CYCLES, pulse done_valid with done_resp=2'b10, drop bready_in and return to IDLE; counter clears on entering RESP.
REQ-025 SHALL, without AXI_WR_TIMEOUT_EN, wait in RESP indefinitely and contain no watchdog counter logic.

Verification
REQ-026 SHALL cover: req addr=0x1000, len=3, size=3, burst=INCR, awready and wready always 1, bvalid 2 cycles after last beat resp=0 -> awvalid_in 1 cycle, 4 W beats, wlast on 4th only, one done_valid with done_resp=0.
REQ-027 SHALL cover: len=0 with awready delayed 5 cycles -> awvalid_in held 5 cycles with stable awaddr_in, single beat carries wlast=1.
REQ-028 SHALL cover: len=7, din_valid and axi_wready toggled randomly -> exactly 8 handshakes, data order preserved, wlast only on 8th, din_ready never high outside DATA.
REQ-029 SHALL cover: resetn low for 1 cycle during DATA after 2 of 4 beats -> all outputs 0 next cycle, no done_valid, next request starts a fresh burst with counter at 0.
REQ-030 SHALL cover: with AXI_WR_TIMEOUT_EN, TIMEOUT_CYCLES=16, bvalid never asserted -> done_valid after 16 RESP cycles with done_resp=2'b10; without the macro, no done_valid after 1000 cycles.
